// File: rtl/led_pattern_gen_pkg.sv
// led_pkg: shared mode and direction encodings for the LED pattern generator
package led_pkg;

    // Pattern modes selected by the mode input
    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_RUN    = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    // Travel direction of the lit bit in bounce mode
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// tick_prescaler: programmable divider emitting a one-cycle tick every div+1 enabled cycles
//   clk       in  system clock
//   rst_n     in  synchronous active-low reset
//   enable    in  1 = count, 0 = hold count and suppress tick
//   div_value in  divide value latched on load_div
//   load_div  in  strobe: latch div_value and restart the count
//   tick      out registered one-cycle pulse on each wrap
module tick_prescaler #(
    parameter int               DIV_W       = 24,
    parameter logic [DIV_W-1:0] DIV_DEFAULT = 24'd12_499_999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_value,
    input  logic             load_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             wrap;

    assign wrap = cnt_q == div_q;

    // A load restarts the count and wins over the wrap compare, even while disabled
    always_comb begin
        div_d  = load_div ? div_value : div_q;
        cnt_d  = load_div ? '0 : !enable ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
        tick_d = !load_div && enable && wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= DIV_DEFAULT;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled pattern engine driving N_LED board LEDs (off, blink, run, bounce)
//   clk       in  system clock
//   rst_n     in  synchronous active-low reset
//   enable    in  1 = prescaler and pattern run, 0 = freeze
//   div_value in  divide value; tick period is div_value+1 cycles
//   load_div  in  strobe: latch div_value
//   mode      in  0 OFF, 1 BLINK, 2 RUN, 3 BOUNCE
//   tick      out registered one-cycle prescaler pulse
//   HW_led    out registered LED drive, 1 = lit
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int               DIV_W       = 24,
    parameter int               N_LED       = 8,
    parameter logic [DIV_W-1:0] DIV_DEFAULT = 24'd12_499_999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_value,
    input  logic             load_div,
    input  logic [1:0]       mode,
    output logic             tick,
    output logic [N_LED-1:0] HW_led
);

    localparam logic [N_LED-1:0] BIT0 = {{(N_LED-1){1'b0}}, 1'b1};

    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d;
    logic [N_LED-1:0] pattern_q, pattern_d;
    logic [N_LED-1:0] led_q;

    tick_prescaler #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .div_value (div_value),
        .load_div  (load_div),
        .tick      (tick)
    );

    // A mode change re-initialises the pattern and swallows any tick of the same cycle
    always_comb begin
        mode_d    = mode_q;
        dir_d     = dir_q;
        pattern_d = pattern_q;
        if (mode != mode_q) begin
            mode_d    = mode_e'(mode);
            dir_d     = DIR_LEFT;
            pattern_d = (mode == MODE_OFF) ? '0 : (mode == MODE_BLINK) ? '1 : BIT0;
        end else if (tick && enable) begin
            unique case (mode_q)
                MODE_OFF:    pattern_d = '0;
                MODE_BLINK:  pattern_d = ~pattern_q;
                MODE_RUN:    pattern_d = {pattern_q[N_LED-2:0], pattern_q[N_LED-1]};
                MODE_BOUNCE: begin
                    pattern_d = (dir_q == DIR_LEFT) ? pattern_q << 1 : pattern_q >> 1;
                    // Turn around on arrival so each end bit is lit for exactly one tick
                    dir_d = pattern_d[N_LED-1] ? DIR_RIGHT : pattern_d[0] ? DIR_LEFT : dir_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= MODE_OFF;
            dir_q     <= DIR_LEFT;
            pattern_q <= '0;
            led_q     <= '0;
        end else begin
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            pattern_q <= pattern_d;
            if (enable) led_q <= pattern_q;
        end
    end

    assign HW_led = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed bench with a step-index model of the LED pattern generator
module tb_led_pattern_gen;

    localparam int N  = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n, enable, load_div;
    logic [DW-1:0] div_value;
    logic [1:0]    mode;
    logic          tick;
    logic [N-1:0]  HW_led;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .DIV_W       (DW),
        .N_LED       (N),
        .DIV_DEFAULT (4'd3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .div_value (div_value),
        .load_div  (load_div),
        .mode      (mode),
        .tick      (tick),
        .HW_led    (HW_led)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Pattern as a function of mode and number of steps taken since (re)initialisation
    function automatic logic [N-1:0] pat(input logic [1:0] md, input int k);
        int p;
        case (md)
            2'd0:    return '0;
            2'd1:    return (k % 2 == 0) ? {N{1'b1}} : {N{1'b0}};
            2'd2:    return N'(1) << (k % N);
            default: begin
                p = k % (2 * N - 2);
                return N'(1) << ((p < N) ? p : 2 * N - 2 - p);
            end
        endcase
    endfunction

    // Model: tick fires when the enabled-cycle count since load hits div modulo div+1
    logic          m_tick;
    logic [DW-1:0] m_div;
    logic [1:0]    m_mode;
    logic [N-1:0]  m_led;
    int            m_n, m_k;
    bit            started = 1'b0;

    always @(posedge clk) begin
        started <= 1'b1;
        if (!rst_n) begin
            m_tick <= 1'b0;
            m_div  <= 4'd3;
            m_mode <= 2'd0;
            m_led  <= '0;
            m_n    <= 0;
            m_k    <= 0;
        end else begin
            if (load_div) begin
                m_div  <= div_value;
                m_n    <= 0;
                m_tick <= 1'b0;
            end else if (enable) begin
                m_tick <= (m_n % (int'(m_div) + 1)) == int'(m_div);
                m_n    <= m_n + 1;
            end else begin
                m_tick <= 1'b0;
            end
            if (mode != m_mode) begin
                m_mode <= mode;
                m_k    <= 0;
            end else if (m_tick && enable) begin
                m_k <= m_k + 1;
            end
            if (enable) m_led <= pat(m_mode, m_k);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_tick", 32'(tick), 32'(m_tick));
            check("model_led", 32'(HW_led), 32'(m_led));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [N-1:0] bounce_exp [8];

    initial begin
        bounce_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        rst_n     = 1'b0;
        enable    = 1'b0;
        load_div  = 1'b0;
        div_value = '0;
        mode      = 2'd0;

        // Reset, then OFF with the default divide of 3
        cyc(3);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_led", 32'(HW_led), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            check("off_tick", 32'(tick), 32'(i % 4 == 0));
        end
        check("off_led", 32'(HW_led), 32'd0);

        // BLINK with divide 1
        mode      = 2'd1;
        load_div  = 1'b1;
        div_value = 4'd1;
        cyc();
        load_div = 1'b0;
        cyc();
        check("blink_init", 32'(HW_led), 32'hF);
        cyc();
        check("blink_tick", 32'(tick), 32'd1);
        cyc(2);
        check("blink_off", 32'(HW_led), 32'h0);
        cyc(2);
        check("blink_on", 32'(HW_led), 32'hF);

        // RUN with divide 0: tick every cycle, wrap bit3 -> bit0
        mode      = 2'd2;
        load_div  = 1'b1;
        div_value = 4'd0;
        cyc();
        load_div = 1'b0;
        cyc();
        check("run_tick", 32'(tick), 32'd1);
        cyc();
        check("run_0", 32'(HW_led), 32'h1);
        cyc();
        check("run_1", 32'(HW_led), 32'h2);
        cyc();
        check("run_2", 32'(HW_led), 32'h4);
        cyc();
        check("run_3", 32'(HW_led), 32'h8);
        cyc();
        check("run_wrap", 32'(HW_led), 32'h1);

        // BOUNCE: the pending tick is swallowed by the mode change
        mode = 2'd3;
        cyc();
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("bounce_seq", 32'(HW_led), 32'(bounce_exp[i]));
        end

        // RUN freeze at 0100 for 5 cycles, then resume at 1000
        mode = 2'd2;
        cyc();
        cyc(3);
        check("frz_pre", 32'(HW_led), 32'h4);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("frz_led", 32'(HW_led), 32'h4);
            check("frz_tick", 32'(tick), 32'd0);
        end
        enable = 1'b1;
        cyc();
        check("frz_resume", 32'(HW_led), 32'h8);
        cyc(2);
        check("frz_wrap", 32'(HW_led), 32'h1);

        // Reset mid-BOUNCE while tick is high and a load is requested
        mode = 2'd3;
        cyc(3);
        check("rst2_tick_pre", 32'(tick), 32'd1);
        rst_n     = 1'b0;
        load_div  = 1'b1;
        div_value = 4'd5;
        cyc();
        check("rst2_led", 32'(HW_led), 32'd0);
        check("rst2_tick", 32'(tick), 32'd0);
        rst_n    = 1'b1;
        load_div = 1'b0;
        cyc();
        check("rst2_f1_led", 32'(HW_led), 32'd0);
        check("rst2_f1_tick", 32'(tick), 32'd0);
        cyc();
        check("rst2_f2_led", 32'(HW_led), 32'h1);
        check("rst2_f2_tick", 32'(tick), 32'd0);
        cyc();
        check("rst2_f3_tick", 32'(tick), 32'd0);
        cyc();
        check("rst2_f4_tick", 32'(tick), 32'd1);
        cyc(2);
        check("rst2_f6_led", 32'(HW_led), 32'h2);

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor of the single-LED counter blinker and its tick toggler.
- A programmable prescaler produces a one-cycle tick from `clk`.
- Each tick advances a pattern engine that drives N_LED board LEDs in one of four modes: off, blink, running light, bounce.
- Sits between the board clock and the `HW_led` pins; fed by switches/buttons or a register interface.

Parameters:
- DIV_W, 24, width of prescaler counter and divide value.
- N_LED, 8, number of LED outputs; legal range 2..32.
- DIV_DEFAULT, 24'd12_499_999, divide value loaded at reset. At 25 MHz this gives a 2 Hz tick.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  1 = prescaler and pattern run; 0 = freeze.
- div_value  in  DIV_W  new divide value; tick period = div_value+1 cycles.
- load_div  in  1  one-cycle strobe: latch div_value.
- mode  in  2  0 OFF, 1 BLINK, 2 RUN, 3 BOUNCE.
- tick  out  1  registered one-cycle pulse at each prescaler wrap.
- HW_led  out  N_LED  registered LED drive, 1 = lit.

Behaviour:
- Reset, sampled on posedge when rst_n=0:
  - cnt=0, div_reg=DIV_DEFAULT, tick=0, pattern=0, dir=left, mode_q=0, HW_led=0.
  - Reset overrides every other input in the same cycle.
- Prescaler:
  - When enable=1: if cnt==div_reg, then cnt<=0 and tick<=1; else cnt<=cnt+1 and tick<=0.
  - div_reg=0 gives tick=1 every cycle.
  - Counter arithmetic is unsigned DIV_W; the counter never exceeds div_reg, so no wrap beyond div_reg.
  - When enable=0: cnt holds, tick<=0.
- load_div=1:
  - div_reg<=div_value and cnt<=0 next cycle; tick<=0 that cycle.
  - Takes priority over the wrap compare.
  - Honoured even when enable=0.
- Mode change (mode != mode_q), regardless of enable:
  - Next cycle mode_q<=mode and pattern is re-initialised: OFF 0, BLINK all-ones, RUN one-hot bit0, BOUNCE one-hot bit0 with dir=left.
  - Any tick in that same cycle is ignored by the pattern engine; the prescaler is not reset.
- Pattern step: in the cycle after tick=1 with mode==mode_q and enable=1:
  - OFF: pattern stays 0.
  - BLINK: pattern <= ~pattern.
  - RUN: rotate left by 1; bit N_LED-1 wraps to bit0.
  - BOUNCE: shift in dir. When the lit bit reaches N_LED-1, dir<=right; when it reaches bit0, dir<=left. End bits are lit for exactly one tick each (sequence for 4 LEDs: 0001,0010,0100,1000,0100,0010,0001,0010...).
- HW_led <= pattern, registered: 1 cycle after pattern, 2 cycles after tick.
- enable=0 freezes pattern and HW_led; enable rising resumes from the held cnt.
- Pattern is always one-hot in RUN/BOUNCE; a non-one-hot value is impossible by construction.

Decomposition:
- Package led_pkg:
  - Mode constants MODE_OFF=2'd0, MODE_BLINK=2'd1, MODE_RUN=2'd2, MODE_BOUNCE=2'd3.
  - Direction constants DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
- Sub-module tick_prescaler (DIV_W, DIV_DEFAULT; ports clk, rst_n, enable, div_value, load_div, tick).
  - Reusable by other blinker/timer blocks.
  - The pattern engine stays in the top.

Test Plan (N_LED=4, DIV_W=4, DIV_DEFAULT=4'd3):
1. Reset held 3 cycles, then enable=1, mode=0 -> HW_led=0000 and tick=0 during reset; tick pulses every 4 cycles thereafter; HW_led stays 0000.
2. load_div with div_value=1, mode=1 -> tick every 2 cycles; HW_led after init 1111, then 0000, 1111, 0000, toggling 2 cycles after each tick.
3. mode=2, div_value=0 -> HW_led 0001,0010,0100,1000,0001 on successive cycles; wrap from bit3 to bit0 verified.
4. mode=3, div_value=0 -> HW_led 0001,0010,0100,1000,0100,0010,0001,0010; no repeated end state.
5. In mode=2, drop enable for 5 cycles mid-sequence at HW_led=0100 -> HW_led and cnt hold, tick=0; on re-enable the sequence continues 1000.
6. Assert rst_n=0 mid-BOUNCE while tick=1 and load_div=1 -> next cycle all outputs 0, div_reg=3, mode_q=0; after release with mode=3 the pattern restarts at 0001, dir=left.
